// File: rtl/pool_pkg.sv
// pool_pkg: shared defaults, state encoding and sizing helpers for the
// streaming max-pool stage (maxpool_stream) and its output register.
package pool_pkg;

  // Default geometry: 8-bit signed data, 5-value vectors, windows of 2.
  localparam int T_DEF      = 8;
  localparam int VECLEN_DEF = 5;
  localparam int POOL_DEF   = 2;

  // Raw counter widths for the default geometry.
  localparam int POS_W_DEF  = $clog2(VECLEN_DEF);
  localparam int WIN_W_DEF  = $clog2(POOL_DEF);

  // Window phase: FIRST loads the accumulator, ACCUM folds in a max.
  typedef enum logic {
    FIRST = 1'b0,
    ACCUM = 1'b1
  } pool_state_e;

  // Pooled outputs per vector; the last window may be partial.
  function automatic int num_out(input int veclen, input int pool);
    return (veclen + pool - 1) / pool;
  endfunction

  // Counter width for a 0..n-1 counter. $clog2(1) is 0, so clamp to 1 bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pool_out_reg.sv
// pool_out_reg: single-entry output register for the pooled result stream.
// Ports:
//   clk, reset       - clock, asynchronous active-low reset
//   load_i           - a closing value was accepted; capture data_i/last_i
//   data_i, last_i   - final window maximum and end-of-vector flag
//   m_ready_i        - downstream consumes the held entry this cycle
//   m_data_o/m_valid_o/m_last_o - registered output stream
module pool_out_reg
  import pool_pkg::*;
#(
  parameter int T = T_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load_i,
  input  logic signed [T-1:0] data_i,
  input  logic                last_i,
  input  logic                m_ready_i,
  output logic signed [T-1:0] m_data_o,
  output logic                m_valid_o,
  output logic                m_last_o
);

  logic signed [T-1:0] data_q;
  logic                valid_q;
  logic                last_q;

  // Output entry: a load always wins (it also covers the same-edge transfer,
  // so the stream has no bubble); a bare transfer empties the entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else if (load_i) begin
      data_q  <= data_i;
      valid_q <= 1'b1;
      last_q  <= last_i;
    end else if (valid_q && m_ready_i) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_q;
    end
  end

  assign m_data_o  = data_q;
  assign m_valid_o = valid_q;
  assign m_last_o  = last_q;

endmodule

// File: rtl/maxpool_stream.sv
// maxpool_stream: streaming 1-D max-pool. Splits each VECLEN-value vector
// into non-overlapping POOL-value windows and emits each window's signed max.
// Ports:
//   clk, reset          - clock, asynchronous active-low reset
//   s_data_in/s_valid/s_ready   - input value stream (valid/ready)
//   m_data_out/m_valid/m_ready  - pooled maximum stream (valid/ready)
//   m_last              - marks the final pooled value of a vector
module maxpool_stream
  import pool_pkg::*;
#(
  parameter int T      = T_DEF,
  parameter int VECLEN = VECLEN_DEF,
  parameter int POOL   = POOL_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic signed [T-1:0] s_data_in,
  input  logic                s_valid,
  output logic                s_ready,
  output logic signed [T-1:0] m_data_out,
  output logic                m_valid,
  input  logic                m_ready,
  output logic                m_last
);

  localparam int POS_W = cnt_w(VECLEN);
  localparam int WIN_W = cnt_w(POOL);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(VECLEN - 1);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(POOL - 1);

  pool_state_e         state_q;
  logic [POS_W-1:0]    pos_q;
  logic [WIN_W-1:0]    win_q;
  logic signed [T-1:0] acc_q;
  logic                rdy_en_q;

  logic                close_s;
  logic                vec_end_s;
  logic                accept_s;
  logic                load_s;
  logic signed [T-1:0] max_s;

  // The next value closes a window at the window edge or at vector end.
  assign vec_end_s = (pos_q == POS_LAST);
  assign close_s   = (win_q == WIN_LAST) || vec_end_s;

  // rdy_en_q keeps s_ready low in reset and until the first edge after it.
  // Only a closing value needs the output slot, so only that one stalls.
  assign s_ready  = rdy_en_q && !(close_s && m_valid && !m_ready);
  assign accept_s = s_valid && s_ready;
  assign load_s   = accept_s && close_s;

  // In FIRST the incoming value starts the window; otherwise signed max.
  assign max_s = ((state_q == ACCUM) && (acc_q > s_data_in)) ? acc_q : s_data_in;

  // Window/vector sequencing and accumulator.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= FIRST;
      pos_q    <= '0;
      win_q    <= '0;
      acc_q    <= '0;
      rdy_en_q <= 1'b0;
    end else begin
      rdy_en_q <= 1'b1;
      if (accept_s) begin
        case (state_q)
          FIRST:   acc_q <= s_data_in;
          ACCUM:   acc_q <= max_s;
          default: acc_q <= s_data_in;
        endcase
        if (close_s) begin
          win_q   <= '0;
          state_q <= FIRST;
        end else begin
          win_q   <= win_q + WIN_W'(1);
          state_q <= ACCUM;
        end
        pos_q <= vec_end_s ? '0 : pos_q + POS_W'(1);
      end else begin
        acc_q <= acc_q;
      end
    end
  end

  pool_out_reg #(
    .T (T)
  ) u_out (
    .clk       (clk),
    .reset     (reset),
    .load_i    (load_s),
    .data_i    (max_s),
    .last_i    (vec_end_s),
    .m_ready_i (m_ready),
    .m_data_o  (m_data_out),
    .m_valid_o (m_valid),
    .m_last_o  (m_last)
  );

endmodule

// File: tb/tb_maxpool_stream.sv
module tb_maxpool_stream;
  import pool_pkg::*;

  logic              clk;
  logic              reset;
  logic signed [7:0] s_data_in;
  logic              s_valid;
  logic              s_ready;
  logic signed [7:0] m_data_out;
  logic              m_valid;
  logic              m_ready;
  logic              m_last;

  int checks;
  int errors;
  int stall_cnt;
  bit rnd_mode;

  logic signed [7:0] out_d[$];
  bit                out_l[$];
  logic signed [7:0] exp_d[$];
  bit                exp_l[$];

  maxpool_stream #(.T(8), .VECLEN(5), .POOL(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .s_data_in  (s_data_in),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .m_data_out (m_data_out),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_last     (m_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change only just after posedge, so the negedge view is what the
  // next posedge will act on: record each output transfer there.
  always @(negedge clk) begin
    if (reset && m_valid && m_ready) begin
      out_d.push_back(m_data_out);
      out_l.push_back(m_last);
    end
  end

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic expo(input logic signed [7:0] d, input bit l);
    exp_d.push_back(d);
    exp_l.push_back(l);
  endtask

  task automatic rnd_ready();
    if (rnd_mode) m_ready = 1'($urandom_range(0, 1));
  endtask

  // Present one value and hold it until accepted (bounded).
  task automatic send(input logic [7:0] v);
    int n;
    n = 0;
    s_valid   = 1'b1;
    s_data_in = v;
    @(negedge clk);
    while (!s_ready && n < 500) begin
      @(posedge clk); #1;
      rnd_ready();
      n++;
      @(negedge clk);
    end
    if (!s_ready) chk("send_timeout", 32'sd0, 32'sd1);
    stall_cnt += n;
    @(posedge clk); #1;
    s_valid = 1'b0;
    rnd_ready();
    if (rnd_mode) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
        rnd_ready();
      end
    end
  endtask

  // Let all expected outputs drain, then compare against the expectations.
  task automatic drain_cmp(input string tag);
    int n;
    int lim;
    n = 0;
    m_ready = 1'b1;
    while (out_d.size() < exp_d.size() && n < 20000) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_count"}, out_d.size(), exp_d.size());
    lim = (out_d.size() < exp_d.size()) ? out_d.size() : exp_d.size();
    for (int i = 0; i < lim; i++) begin
      chk($sformatf("%s_data%0d", tag, i), out_d[i], exp_d[i]);
      chk($sformatf("%s_last%0d", tag, i), 32'(out_l[i]), 32'(exp_l[i]));
    end
    out_d.delete(); out_l.delete();
    exp_d.delete(); exp_l.delete();
  endtask

  initial begin
    logic signed [7:0] vals [5];
    logic signed [7:0] mx;
    int nlast;
    int nout;

    checks = 0; errors = 0; stall_cnt = 0; rnd_mode = 1'b0;
    reset = 1'b0; s_valid = 1'b0; s_data_in = 8'sd0; m_ready = 1'b1;

    // Reset state
    #2;
    chk("rst_m_valid", 32'(m_valid), 32'sd0);
    chk("rst_s_ready", 32'(s_ready), 32'sd0);
    chk("rst_m_data", m_data_out, 32'sd0);
    chk("rst_m_last", 32'(m_last), 32'sd0);
    @(posedge clk); #1;
    reset = 1'b1;
    #1 chk("rst_rel_s_ready_low", 32'(s_ready), 32'sd0);
    @(posedge clk); #1;
    chk("rst_rel_s_ready_high", 32'(s_ready), 32'sd1);

    // Basic vector 3,7,0,5,2 -> 7,5,2
    stall_cnt = 0;
    send(8'd3);
    chk("basic_no_out_yet", 32'(m_valid), 32'sd0);
    send(8'd7);
    chk("basic_lat_valid", 32'(m_valid), 32'sd1);
    chk("basic_lat_data", m_data_out, 32'sd7);
    send(8'd0); send(8'd5); send(8'd2);
    expo(8'sd7, 1'b0); expo(8'sd5, 1'b0); expo(8'sd2, 1'b1);
    chk("basic_stalls", stall_cnt, 32'sd0);
    drain_cmp("basic");

    // Signed compare
    send(8'hFC); send(8'hF7); send(8'h80); send(8'hFF); send(8'h7F);
    expo(-8'sd4, 1'b0); expo(-8'sd1, 1'b0); expo(8'sd127, 1'b1);
    drain_cmp("signed");

    // Backpressure: hold output 7 while the stream advances
    send(8'd3); send(8'd7);
    m_ready = 1'b0;
    stall_cnt = 0;
    send(8'd0);
    chk("bp_nonclose_accepted", stall_cnt, 32'sd0);
    s_valid = 1'b1; s_data_in = 8'sd5;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("bp_s_ready_low%0d", i), 32'(s_ready), 32'sd0);
      chk($sformatf("bp_hold_data%0d", i), m_data_out, 32'sd7);
      chk($sformatf("bp_hold_valid%0d", i), 32'(m_valid), 32'sd1);
    end
    @(posedge clk); #1;
    m_ready = 1'b1;
    #1 chk("bp_s_ready_release", 32'(s_ready), 32'sd1);
    send(8'd5);
    chk("bp_no_bubble", 32'(m_valid), 32'sd1);
    chk("bp_new_data", m_data_out, 32'sd5);
    send(8'd2);
    expo(8'sd7, 1'b0); expo(8'sd5, 1'b0); expo(8'sd2, 1'b1);
    drain_cmp("bp");

    // Back-to-back vectors
    stall_cnt = 0;
    send(8'd3); send(8'd7); send(8'd0); send(8'd5); send(8'd2);
    send(8'd1); send(8'd1); send(8'd9); send(8'd8); send(8'd6);
    chk("b2b_stalls", stall_cnt, 32'sd0);
    expo(8'sd7, 1'b0); expo(8'sd5, 1'b0); expo(8'sd2, 1'b1);
    expo(8'sd1, 1'b0); expo(8'sd9, 1'b0); expo(8'sd6, 1'b1);
    drain_cmp("b2b");

    // Reset mid-window
    send(8'd3); send(8'd7); send(8'd0);
    reset = 1'b0;
    #1;
    chk("mid_rst_m_valid", 32'(m_valid), 32'sd0);
    chk("mid_rst_s_ready", 32'(s_ready), 32'sd0);
    chk("mid_rst_m_data", m_data_out, 32'sd0);
    @(posedge clk); #1;
    reset = 1'b1;
    out_d.delete(); out_l.delete();
    send(8'd4); send(8'd1); send(8'd2); send(8'd6); send(8'd5);
    expo(8'sd4, 1'b0); expo(8'sd6, 1'b0); expo(8'sd5, 1'b1);
    drain_cmp("mid_rst");

    // Random valid/ready against a software max-pool model
    rnd_mode = 1'b1;
    for (int v = 0; v < 1000; v++) begin
      for (int k = 0; k < 5; k++) vals[k] = 8'($urandom_range(0, 255));
      for (int st = 0; st < 5; st += 2) begin
        mx = vals[st];
        for (int k = st; k < st + 2 && k < 5; k++) if (vals[k] > mx) mx = vals[k];
        expo(mx, (st + 2 >= 5));
      end
      for (int k = 0; k < 5; k++) send(vals[k]);
    end
    rnd_mode = 1'b0;
    nlast = 0;
    foreach (exp_l[i]) if (exp_l[i]) nlast++;
    chk("rnd_model_lasts", nlast, 32'sd1000);
    nout = 1000 * num_out(5, 2);
    chk("rnd_model_outs", exp_d.size(), nout);
    drain_cmp("rnd");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
